instr_register_param: RTL and testbench
=======================================

// Module: instr_register_param
// PURPOSE
//  Parametrised instruction register: stores DEPTH entries of {opcode, operand_a, operand_b, result}.
//  Result is computed at write time by an ALU.
//  Tracks a per-entry valid bitmap, an occupancy count and a divide-by-zero flag.
//  Serves a registered read port. Sits between the stimulus/decode side and the execute/checker side.
// PARAMETERS
//  DEPTH  32  number of entries; power of 2, >=2
//  OPW    8   operand width in bits; operands are signed two's complement
//  AW     $clog2(DEPTH)  pointer width (derived, localparam)
//  RW     2*OPW          result width (derived, localparam)
// PORTS
//  clk            in   1    single clock; all state updates on rising edge
//  reset          in   1    synchronous, active-high reset
//  load_en        in   1    write strobe
//  write_pointer  in   AW   write address
//  opcode         in   3    opcode_t: ZERO,PASSA,PASSB,ADD,SUB,MULT,DIV,MOD = 0..7
//  operand_a      in   OPW  signed operand A
//  operand_b      in   OPW  signed operand B
//  read_en        in   1    read strobe
//  read_pointer   in   AW   read address
//  clear_all      in   1    invalidate every entry (array contents not required to be zeroed)
//  rd_opcode      out  3    read data, opcode
//  rd_operand_a   out  OPW  read data, operand A
//  rd_operand_b   out  OPW  read data, operand B
//  rd_result      out  RW   read data, signed result
//  rd_div_err     out  1    read data, entry was DIV/MOD with operand_b==0
//  rd_valid       out  1    read data is from a written entry; pulses 1 cycle per read_en
//  valid_count    out  AW+1 number of valid entries
//  full           out  1    valid_count==DEPTH
// BEHAVIOUR
//  Reset (synchronous):
//   - every output, the valid bitmap and the count go to 0 at the next clk edge after reset=1.
//   - Reset mid-operation discards any write/read presented in that cycle.
//  Write (0-cycle commit):
//   - load_en=1 at edge N stores the inputs, the ALU result and div_err into entry write_pointer.
//   - Sets valid[write_pointer] at edge N.
//  ALU (combinational, sign-extend operands to RW):
//   - ZERO=0; PASSA=a; PASSB=b; ADD=a+b; SUB=a-b; MULT=a*b (exact in RW).
//   - DIV=a/b, truncates toward zero.
//   - MOD=a%b, sign of a.
//   - b==0 for DIV/MOD -> result 0, div_err=1; div_err=0 for every other case.
//  Read (1-cycle latency):
//   - read_en=1 at edge N -> rd_* hold entry read_pointer after edge N.
//   - rd_valid=valid[read_pointer]; unwritten entry -> rd_valid=0 and all rd_* fields 0.
//   - read_en=0 -> rd_valid=0 next cycle; rd_* data fields hold their last value.
//  Same-address read and write in one cycle: read-first; returns old contents and old valid bit.
//  valid_count:
//   - +1 only when writing to a currently invalid entry; overwrite leaves it unchanged.
//   - Never exceeds DEPTH; writes when full are accepted (they can only overwrite).
//  clear_all with load_en in the same cycle:
//   - clear applies first, the write is kept -> valid_count=1.
//   - A read in that cycle sees pre-clear state.
//  Pointers are exactly AW bits, so no out-of-range address exists; no wrap logic is needed.
// STRUCTURE
//  Shared package instr_register_pkg holds:
//   - opcode_t (3-bit enum).
//   - Typedef for the stored entry; fields sized via package constants matching OPW defaults.
//  Sub-module instr_alu (parameter OPW): combinational; ports a, b, opcode -> result[RW], div_err.
//  Top holds the array, valid bitmap, counter and read register.
// TESTING  (DEPTH=32, OPW=8)
//  - Reset held 2 cycles, then idle -> all outputs 0, valid_count=0, full=0.
//  - Write ADD a=5 b=-3 @2; read @2 -> rd_valid=1, rd_result=2, rd_div_err=0 one cycle after read_en.
//  - Write MULT a=-15 b=15 @0 -> read -225 (16'hFF1F).
//  - Write DIV a=7 b=0 @1 -> read result 0, rd_div_err=1.
//  - Write MOD a=-7 b=2 @5 -> read -1.
//  - Read never-written @9 -> rd_valid=0, rd_* = 0.
//  - Write @3 twice -> valid_count=1; then 31 distinct writes -> valid_count=32, full=1.
//  - Same-cycle read+write @4 (old ADD 1+1, new SUB 9-4) -> rd_result=2; next read @4 -> 5.
//  - clear_all + load_en @6 same cycle -> valid_count=1; read @2 -> rd_valid=0; read @6 -> rd_valid=1.
//  - Assert reset mid-stream with load_en=1 -> write dropped, valid_count=0, rd_valid=0.

Source files
------------

// File: rtl/instr_register_pkg.sv
// Shared types for the parametrised instruction register.
// Opcode encoding and the default-width stored entry.
package instr_register_pkg;

  localparam int DEF_OPW = 8;
  localparam int DEF_RW  = 2 * DEF_OPW;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef struct packed {
    opcode_t             opcode;
    logic [DEF_OPW-1:0]  operand_a;
    logic [DEF_OPW-1:0]  operand_b;
    logic [DEF_RW-1:0]   result;
    logic                div_err;
  } entry_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational ALU evaluated at write time.
// Operands are signed and widened to 2*OPW before use.
module instr_alu
  import instr_register_pkg::*;
#(
  parameter  int OPW = 8,
  localparam int RW  = 2 * OPW
) (
  input  logic signed [OPW-1:0] a,
  input  logic signed [OPW-1:0] b,
  input  opcode_t               opcode,
  output logic signed [RW-1:0]  result,
  output logic                  div_err
);

  logic signed [RW-1:0] a_x;
  logic signed [RW-1:0] b_x;
  logic                 b_zero;

  assign a_x    = {{OPW{a[OPW-1]}}, a};
  assign b_x    = {{OPW{b[OPW-1]}}, b};
  assign b_zero = (b == '0);

  // Opcode decode; division by zero yields 0 and raises div_err.
  always_comb begin
    result  = '0;
    div_err = 1'b0;
    unique case (opcode)
      ZERO:  result = '0;
      PASSA: result = a_x;
      PASSB: result = b_x;
      ADD:   result = a_x + b_x;
      SUB:   result = a_x - b_x;
      MULT:  result = a_x * b_x;
      DIV: begin
        if (b_zero) div_err = 1'b1;
        else        result  = a_x / b_x;
      end
      MOD: begin
        if (b_zero) div_err = 1'b1;
        else        result  = a_x % b_x;
      end
    endcase
  end

endmodule

// File: rtl/instr_register_param.sv
// Instruction register: DEPTH entries with write-time ALU,
// valid bitmap, occupancy count and a registered read port.
module instr_register_param
  import instr_register_pkg::*;
#(
  parameter  int DEPTH = 32,
  parameter  int OPW   = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int RW    = 2 * OPW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_en,
  input  logic [AW-1:0]         write_pointer,
  input  opcode_t               opcode,
  input  logic signed [OPW-1:0] operand_a,
  input  logic signed [OPW-1:0] operand_b,
  input  logic                  read_en,
  input  logic [AW-1:0]         read_pointer,
  input  logic                  clear_all,
  output opcode_t               rd_opcode,
  output logic signed [OPW-1:0] rd_operand_a,
  output logic signed [OPW-1:0] rd_operand_b,
  output logic signed [RW-1:0]  rd_result,
  output logic                  rd_div_err,
  output logic                  rd_valid,
  output logic [AW:0]           valid_count,
  output logic                  full
);

  typedef struct packed {
    opcode_t               opcode;
    logic signed [OPW-1:0] operand_a;
    logic signed [OPW-1:0] operand_b;
    logic signed [RW-1:0]  result;
    logic                  div_err;
  } ent_t;

  ent_t                 mem [DEPTH];
  logic [DEPTH-1:0]     valid;
  logic signed [RW-1:0] alu_result;
  logic                 alu_err;
  ent_t                 rd_ent;

  instr_alu #(.OPW(OPW)) u_alu (
    .a       (operand_a),
    .b       (operand_b),
    .opcode  (opcode),
    .result  (alu_result),
    .div_err (alu_err)
  );

  assign full   = (valid_count == (AW+1)'(DEPTH));
  assign rd_ent = valid[read_pointer] ? mem[read_pointer] : '0;

  // Entry storage; contents are not reset, validity lives in the bitmap.
  always_ff @(posedge clk) begin
    if (load_en && !reset) begin
      mem[write_pointer] <= '{
        opcode:    opcode,
        operand_a: operand_a,
        operand_b: operand_b,
        result:    alu_result,
        div_err:   alu_err
      };
    end
  end

  // Valid bitmap and occupancy; clear takes effect before a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid       <= '0;
      valid_count <= '0;
    end else if (clear_all) begin
      valid       <= '0;
      valid_count <= '0;
      if (load_en) begin
        valid[write_pointer] <= 1'b1;
        valid_count          <= (AW+1)'(1);
      end
    end else if (load_en) begin
      valid[write_pointer] <= 1'b1;
      if (!valid[write_pointer]) valid_count <= valid_count + 1'b1;
    end
  end

  // Registered read port; sees pre-write state of the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid     <= 1'b0;
      rd_opcode    <= ZERO;
      rd_operand_a <= '0;
      rd_operand_b <= '0;
      rd_result    <= '0;
      rd_div_err   <= 1'b0;
    end else if (read_en) begin
      rd_valid     <= valid[read_pointer];
      rd_opcode    <= rd_ent.opcode;
      rd_operand_a <= rd_ent.operand_a;
      rd_operand_b <= rd_ent.operand_b;
      rd_result    <= rd_ent.result;
      rd_div_err   <= rd_ent.div_err;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_register_param.sv
// Scoreboard bench for instr_register_param (DEPTH=32, OPW=8).
// Directed cases followed by randomized traffic.
module tb_instr_register_param;
  import instr_register_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_en = 1'b0;
  logic [4:0]  write_pointer = '0;
  opcode_t     opcode = ZERO;
  logic [7:0]  operand_a = '0;
  logic [7:0]  operand_b = '0;
  logic        read_en = 1'b0;
  logic [4:0]  read_pointer = '0;
  logic        clear_all = 1'b0;
  opcode_t     rd_opcode;
  logic [7:0]  rd_operand_a;
  logic [7:0]  rd_operand_b;
  logic [15:0] rd_result;
  logic        rd_div_err;
  logic        rd_valid;
  logic [5:0]  valid_count;
  logic        full;

  instr_register_param dut (
    .clk           (clk),
    .reset         (reset),
    .load_en       (load_en),
    .write_pointer (write_pointer),
    .opcode        (opcode),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .read_en       (read_en),
    .read_pointer  (read_pointer),
    .clear_all     (clear_all),
    .rd_opcode     (rd_opcode),
    .rd_operand_a  (rd_operand_a),
    .rd_operand_b  (rd_operand_b),
    .rd_result     (rd_result),
    .rd_div_err    (rd_div_err),
    .rd_valid      (rd_valid),
    .valid_count   (valid_count),
    .full          (full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          tag;
    logic        rv;
    entry_t      ent;
    logic [5:0]  cnt;
    logic        full;
  } exp_t;

  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  entry_t m_mem [32];
  bit     m_vld [32];
  logic   m_rv = 1'b0;
  entry_t m_rd = '0;

  function automatic void alu_m(input opcode_t op, input int a,
                                input int b, output logic [15:0] r,
                                output logic e);
    int v;
    v = 0;
    e = 1'b0;
    case (op)
      ZERO:  v = 0;
      PASSA: v = a;
      PASSB: v = b;
      ADD:   v = a + b;
      SUB:   v = a - b;
      MULT:  v = a * b;
      DIV:   if (b == 0) e = 1'b1; else v = a / b;
      MOD:   if (b == 0) e = 1'b1; else v = a % b;
      default: v = 0;
    endcase
    r = v[15:0];
  endfunction

  task automatic step(input bit rst, input bit ld, input int wp,
                      input opcode_t op, input int a, input int b,
                      input bit rd, input int rp, input bit clr);
    exp_t        x;
    logic [15:0] r;
    logic        e;
    int          n;
    @(negedge clk);
    reset         = rst;
    load_en       = ld;
    write_pointer = wp[4:0];
    opcode        = op;
    operand_a     = a[7:0];
    operand_b     = b[7:0];
    read_en       = rd;
    read_pointer  = rp[4:0];
    clear_all     = clr;
    if (rst) begin
      foreach (m_vld[i]) m_vld[i] = 1'b0;
      m_rv = 1'b0;
      m_rd = '0;
    end else begin
      if (rd) begin
        m_rv = m_vld[rp];
        m_rd = m_vld[rp] ? m_mem[rp] : '0;
      end else begin
        m_rv = 1'b0;
      end
      if (clr) foreach (m_vld[i]) m_vld[i] = 1'b0;
      if (ld) begin
        alu_m(op, a, b, r, e);
        m_mem[wp] = '{opcode: op, operand_a: a[7:0],
                      operand_b: b[7:0], result: r, div_err: e};
        m_vld[wp] = 1'b1;
      end
    end
    n = 0;
    foreach (m_vld[i]) n += int'(m_vld[i]);
    x.tag  = cyc + 1;
    x.rv   = m_rv;
    x.ent  = m_rd;
    x.cnt  = 6'(n);
    x.full = (n == 32);
    sb.push_back(x);
  endtask

  task automatic idle();
    step(0, 0, 0, ZERO, 0, 0, 0, 0, 0);
  endtask

  task automatic wr(input int wp, input opcode_t op, input int a,
                    input int b);
    step(0, 1, wp, op, a, b, 0, 0, 0);
  endtask

  task automatic rdp(input int rp);
    step(0, 0, 0, ZERO, 0, 0, 1, rp, 0);
  endtask

  // Monitor: compares DUT outputs with the expectation due this cycle.
  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0 && sb[0].tag == cyc) begin
      x = sb.pop_front();
      n_cmp++;
      if ({rd_valid, rd_opcode, rd_operand_a, rd_operand_b,
           rd_result, rd_div_err} !== {x.rv, x.ent}) begin
        n_bad++;
        $display("FAIL read cyc=%0d got v=%b op=%0d a=%h b=%h r=%h e=%b want v=%b op=%0d a=%h b=%h r=%h e=%b",
                 cyc, rd_valid, rd_opcode, rd_operand_a, rd_operand_b,
                 rd_result, rd_div_err, x.rv, x.ent.opcode,
                 x.ent.operand_a, x.ent.operand_b, x.ent.result,
                 x.ent.div_err);
      end
      n_cmp++;
      if ({valid_count, full} !== {x.cnt, x.full}) begin
        n_bad++;
        $display("FAIL count cyc=%0d got cnt=%0d full=%b want cnt=%0d full=%b",
                 cyc, valid_count, full, x.cnt, x.full);
      end
    end
  end

  initial begin
    int wp, rp, a, b;
    step(1, 0, 0, ZERO, 0, 0, 0, 0, 0);
    step(1, 0, 0, ZERO, 0, 0, 0, 0, 0);
    idle();
    wr(2, ADD, 5, -3);
    rdp(2);
    wr(0, MULT, -15, 15);
    rdp(0);
    wr(1, DIV, 7, 0);
    rdp(1);
    wr(5, MOD, -7, 2);
    rdp(5);
    rdp(9);
    idle();
    wr(4, ADD, 1, 1);
    step(0, 1, 4, SUB, 9, 4, 1, 4, 0);
    rdp(4);
    step(1, 0, 0, ZERO, 0, 0, 0, 0, 0);
    wr(3, PASSA, 11, 22);
    wr(3, PASSB, 33, 44);
    for (int i = 0; i < 32; i++)
      if (i != 3) wr(i, opcode_t'(i % 8), i - 16, 3 - i);
    wr(7, SUB, -128, 127);
    rdp(7);
    step(0, 1, 6, ADD, 20, 22, 0, 0, 1);
    rdp(2);
    rdp(6);
    for (int i = 0; i < 400; i++) begin
      wp = $urandom_range(0, 31);
      rp = $urandom_range(0, 31);
      a  = int'($urandom_range(0, 255)) - 128;
      b  = ($urandom_range(0, 7) == 0) ? 0
           : int'($urandom_range(0, 255)) - 128;
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) < 6, wp,
           opcode_t'($urandom_range(0, 7)), a, b,
           $urandom_range(0, 9) < 6, rp, $urandom_range(0, 99) < 3);
    end
    wr(10, DIV, -128, -1);
    rdp(10);
    step(1, 1, 12, ADD, 1, 2, 1, 10, 0);
    rdp(12);
    idle();
    idle();
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
